// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, byte type and
// the grant-index width helper.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } arb_state_e;

    typedef logic [7:0] byte_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after
// i_ptr, wrapping modulo NumReq.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int IdW    = id_width(NumReq)
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [IdW-1:0]    i_ptr,
    output logic [IdW-1:0]    o_winner,
    output logic              o_any
);

    always_comb begin : pick
        int idx;
        o_winner = '0;
        o_any    = |i_req;
        // Scan from the far end so the candidate closest to i_ptr is written last.
        for (int k = NumReq - 1; k >= 0; k--) begin
            idx = (int'(i_ptr) + k) % NumReq;
            if (i_req[idx]) begin
                o_winner = IdW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART byte transmitter.
// Optional flow control: define UART_ARB_CTS_EN to gate tx_valid and the lock timeout on cts.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NumReq      = 4,
    parameter int LockTimeout = 1024,
    parameter int IdW         = id_width(NumReq)
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic [NumReq-1:0]   req_valid,
    input  logic [NumReq*8-1:0] req_data,
    input  logic [NumReq-1:0]   req_last,
    output logic [NumReq-1:0]   req_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_done,
    input  logic                cts,
    output logic [IdW-1:0]      grant_id,
    output logic                busy,
    output logic                lock_timeout
);

    localparam int              CntW   = (LockTimeout > 2) ? $clog2(LockTimeout) : 1;
    localparam logic [CntW-1:0] CntMax = (LockTimeout == 0) ? '0 : CntW'(LockTimeout - 1);

    arb_state_e      r_state;
    logic [IdW-1:0]  r_ptr;
    logic [IdW-1:0]  r_grant_id;
    byte_t           r_tx_data;
    logic            r_last_q;
    logic            r_lock_timeout;
    logic [CntW-1:0] r_cnt;

    logic [IdW-1:0]  w_winner;
    logic [IdW-1:0]  w_sel;
    logic [IdW-1:0]  w_next_ptr;
    logic            w_any;
    logic            w_xfer;
    logic            w_cts_ok;
    byte_t           w_bytes [NumReq];

`ifdef UART_ARB_CTS_EN
    assign w_cts_ok = cts;
`else
    logic w_unused_cts;
    assign w_unused_cts = cts;
    assign w_cts_ok     = 1'b1;
`endif

    rr_picker #(
        .NumReq (NumReq),
        .IdW    (IdW)
    ) u_picker (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NumReq; gi++) begin : g_req
            assign w_bytes[gi]   = req_data[8*gi +: 8];
            assign req_ready[gi] = ((r_state == IDLE) && w_any && (w_winner == IdW'(gi)))
                                || ((r_state == HOLD) && (r_grant_id == IdW'(gi)) && req_valid[gi]);
        end
    endgenerate

    assign w_sel      = (r_state == IDLE) ? w_winner : r_grant_id;
    assign w_xfer     = |(req_valid & req_ready);
    assign w_next_ptr = (r_grant_id == IdW'(NumReq - 1)) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_grant_id     <= '0;
            r_tx_data      <= '0;
            r_last_q       <= 1'b0;
            r_lock_timeout <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_lock_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_tx_data  <= w_bytes[w_sel];
                        r_last_q   <= req_last[w_sel];
                        r_grant_id <= w_winner;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    if (w_cts_ok) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (tx_done) begin
                        if (r_last_q) begin
                            r_ptr   <= w_next_ptr;
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // A byte arriving on the timeout cycle still continues the packet.
                    if (w_xfer) begin
                        r_tx_data <= w_bytes[w_sel];
                        r_last_q  <= req_last[w_sel];
                        r_state   <= SEND;
                    end else if (w_cts_ok) begin
                        if ((LockTimeout != 0) && (r_cnt == CntMax)) begin
                            r_lock_timeout <= 1'b1;
                            r_ptr          <= w_next_ptr;
                            r_state        <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_valid     = (r_state == SEND) && w_cts_ok;
    assign grant_id     = r_grant_id;
    assign busy         = (r_state != IDLE);
    assign lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester byte queues, a transmitter
// responder, an expected-byte scoreboard and a table of arbitration vectors.
module tb_uart_tx_arbiter;

    localparam int NumReq = 4;
    localparam int LockTo = 8;
    localparam int IdW    = 2;

    logic                clk       = 1'b0;
    logic                nReset    = 1'b0;
    logic [NumReq-1:0]   req_valid = '0;
    logic [NumReq*8-1:0] req_data  = '0;
    logic [NumReq-1:0]   req_last  = '0;
    logic [NumReq-1:0]   req_ready;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_done   = 1'b0;
    logic                cts       = 1'b1;
    logic [IdW-1:0]      grant_id;
    logic                busy;
    logic                lock_timeout;

    uart_tx_arbiter #(
        .NumReq      (NumReq),
        .LockTimeout (LockTo)
    ) dut (
        .clk          (clk),
        .nReset       (nReset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_done      (tx_done),
        .cts          (cts),
        .grant_id     (grant_id),
        .busy         (busy),
        .lock_timeout (lock_timeout)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; logic last; } rq_t;
    typedef struct { int id; logic [7:0] data; } exp_t;
    typedef struct { logic [3:0] mask; int grant; } vec_t;

    rq_t  rq [NumReq][$];
    exp_t exp_q[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, xfer_cyc = -10, xfer_id = -1, n_xfer = 0;
    int n_tx = 0, n_done = 0, done_cyc = 0, lt_cyc = 0, n_lt = 0;
    int tx_delay = 3, done_cnt = 0;
    bit pending = 1'b0, chk_lat = 1'b1, late_done = 1'b0;
    logic [7:0] inflight = '0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_eq(input string name, input int act, input int req);
        check(act == req, name, act, req);
    endtask

    // One clock: observe outputs at the falling edge, answer the transmitter,
    // present requester bytes and note which one the next rising edge takes.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        tx_done = 1'b0;
        if (late_done) begin
            tx_done   = 1'b1;
            late_done = 1'b0;
        end else if (pending) begin
            done_cnt--;
            if (done_cnt == 0) begin
                tx_done  = 1'b1;
                pending  = 1'b0;
                n_done++;
                done_cyc = cyc;
                check_eq("tx_data_stable", int'(tx_data), int'(inflight));
            end
        end
        if (tx_valid) begin
            n_tx++;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_tx", int'(tx_data), -1);
            end else begin
                e = exp_q.pop_front();
                check_eq("tx_data", int'(tx_data), int'(e.data));
                check_eq("tx_grant", int'(grant_id), e.id);
                if (chk_lat) check_eq("tx_latency", cyc - xfer_cyc, 1);
            end
            inflight = tx_data;
            pending  = 1'b1;
            done_cnt = tx_delay;
        end
        if (lock_timeout) begin
            n_lt++;
            lt_cyc = cyc;
        end
        for (int i = 0; i < NumReq; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rq[i][0].data;
                req_last[i]        = rq[i][0].last;
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
        #1;
        if (req_ready != '0) begin
            check(($countones(req_ready) == 1) && ((req_ready & ~req_valid) == '0),
                  "ready_onehot", int'(req_ready), int'(req_valid));
            for (int i = 0; i < NumReq; i++) begin
                if (req_ready[i] && rq[i].size() > 0) begin
                    rq[i].delete(0);
                    xfer_cyc = cyc;
                    xfer_id  = i;
                    n_xfer++;
                end
            end
        end
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while ((busy || pending || exp_q.size() != 0) && k < bound) begin
            step();
            k++;
        end
        check(k < bound, "idle_bound", k, bound);
    endtask

    task automatic wait_xfer(input int bound);
        int k  = 0;
        int n0 = n_xfer;
        while (n_xfer == n0 && k < bound) begin
            step();
            k++;
        end
        check(n_xfer != n0, "xfer_bound", k, bound);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NumReq; i++) rq[i].delete();
    endtask

    task automatic do_reset();
        clear_reqs();
        exp_q.delete();
        pending   = 1'b0;
        late_done = 1'b0;
        nReset    = 1'b0;
        step();
        step();
        nReset = 1'b1;
    endtask

    // Offer single-byte packets from every requester in mask; exp is the expected winner.
    task automatic arbitrate(input logic [3:0] mask, input int exp, input logic [7:0] base, input string name);
        for (int i = 0; i < NumReq; i++) begin
            if (mask[i]) rq[i].push_back('{8'(base + 8'(i)), 1'b1});
        end
        exp_q.push_back('{exp, 8'(base + 8'(exp))});
        wait_xfer(5);
        check_eq(name, xfer_id, exp);
        clear_reqs();
        wait_idle(60);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [13];
        int   bad;
        int   n0;

        // Pointer enters the table at 3 (after requester 2's packet).
        vecs[0]  = '{4'b1111, 3};
        vecs[1]  = '{4'b1111, 0};
        vecs[2]  = '{4'b1111, 1};
        vecs[3]  = '{4'b1111, 2};
        vecs[4]  = '{4'b1111, 3};
        vecs[5]  = '{4'b1111, 0};
        vecs[6]  = '{4'b0001, 0};
        vecs[7]  = '{4'b1000, 3};
        vecs[8]  = '{4'b0110, 1};
        vecs[9]  = '{4'b1001, 3};
        vecs[10] = '{4'b0100, 2};
        vecs[11] = '{4'b0011, 0};
        vecs[12] = '{4'b1100, 2};

        do_reset();
        check_eq("rst_tx_valid", int'(tx_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_grant_id", int'(grant_id), 0);
        check_eq("rst_tx_data", int'(tx_data), 0);
        check_eq("rst_lock_timeout", int'(lock_timeout), 0);
        check_eq("rst_req_ready", int'(req_ready), 0);

        // Two-byte packet from requester 2, slow transmitter.
        tx_delay = 10;
        n0 = n_done;
        rq[2].push_back('{8'h41, 1'b0});
        rq[2].push_back('{8'h42, 1'b1});
        exp_q.push_back('{2, 8'h41});
        exp_q.push_back('{2, 8'h42});
        bad = 0;
        for (int k = 0; k < 100 && (busy || pending || exp_q.size() != 0); k++) begin
            step();
            if (busy && grant_id != 2'd2) bad++;
        end
        check_eq("t1_grant_held", bad, 0);
        check_eq("t1_busy_drop", int'(busy), 0);
        check_eq("t1_done_count", n_done - n0, 2);

        tx_delay = 3;
        for (int r = 0; r < 13; r++) begin
            for (int i = 0; i < NumReq; i++) begin
                if (vecs[r].mask[i]) rq[i].push_back('{8'(16 * i + r), 1'b1});
            end
            exp_q.push_back('{vecs[r].grant, 8'(16 * vecs[r].grant + r)});
            wait_xfer(5);
            check_eq($sformatf("vec%0d_grant", r), xfer_id, vecs[r].grant);
            clear_reqs();
            wait_idle(60);
        end

        // Requester 0 three-byte packet must not be interleaved with requester 1.
        do_reset();
        n0 = n_done;
        rq[0].push_back('{8'hA0, 1'b0});
        rq[0].push_back('{8'hA1, 1'b0});
        rq[0].push_back('{8'hA2, 1'b1});
        rq[1].push_back('{8'hB0, 1'b1});
        exp_q.push_back('{0, 8'hA0});
        exp_q.push_back('{0, 8'hA1});
        exp_q.push_back('{0, 8'hA2});
        exp_q.push_back('{1, 8'hB0});
        bad = 0;
        for (int k = 0; k < 200 && (busy || pending || exp_q.size() != 0); k++) begin
            step();
            if (req_ready[1] && (rq[0].size() != 0 || (n_done - n0) < 3)) bad++;
        end
        check_eq("t3_no_interleave", bad, 0);
        check_eq("t3_done_count", n_done - n0, 4);

        // Lock timeout: non-last byte, then requester 1 goes quiet.
        n0 = n_lt;
        rq[1].push_back('{8'h55, 1'b0});
        exp_q.push_back('{1, 8'h55});
        for (int k = 0; k < 60 && n_lt == n0; k++) begin
            step();
            if (n_lt != n0) check_eq("to_idle", int'(busy), 0);
        end
        check_eq("to_pulse_seen", n_lt - n0, 1);
        check_eq("to_delay_from_hold", lt_cyc - (done_cyc + 1), LockTo);
        step();
        check_eq("to_pulse_width", int'(lock_timeout), 0);
        arbitrate(4'b1111, 2, 8'hC0, "to_ptr_next");

        // Reset while waiting for the transmitter.
        tx_delay = 30;
        n0 = n_tx;
        rq[3].push_back('{8'h77, 1'b1});
        exp_q.push_back('{3, 8'h77});
        for (int k = 0; k < 10 && n_tx == n0; k++) step();
        check_eq("rw_tx_seen", n_tx - n0, 1);
        step();
        check_eq("rw_in_wait", int'(busy), 1);
        nReset = 1'b0;
        step();
        check_eq("rw_tx_valid", int'(tx_valid), 0);
        check_eq("rw_busy", int'(busy), 0);
        check_eq("rw_grant_id", int'(grant_id), 0);
        check_eq("rw_tx_data", int'(tx_data), 0);
        nReset    = 1'b1;
        pending   = 1'b0;
        late_done = 1'b1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (busy || tx_valid) bad++;
        end
        check_eq("rw_late_done_ignored", bad, 0);
        tx_delay = 3;
        arbitrate(4'b1111, 0, 8'hD0, "rw_ptr_zero");

`ifdef UART_ARB_CTS_EN
        chk_lat = 1'b0;
        cts     = 1'b0;
        rq[2].push_back('{8'h99, 1'b1});
        exp_q.push_back('{2, 8'h99});
        wait_xfer(5);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tx_valid) bad++;
        end
        check_eq("cts_blocked", bad, 0);
        cts = 1'b1;
        n0  = n_tx;
        step();
        check_eq("cts_release", n_tx - n0, 1);
        wait_idle(60);
        chk_lat = 1'b1;
`endif

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
